// File: rtl/sar_adc_seq.sv
// Successive-approximation sequencer for the shared DAC1/comparator path.
// Scans a channel mask: reset, sample, hold, binary-search DAC1, report code.
module sar_adc_seq #(
    parameter int NCH   = 16,
    parameter int DACW  = 10,
    parameter int TSAMP = 4,
    parameter int TSETL = 3
) (
    input  logic                                 i_clk,
    input  logic                                 i_rstz,
    input  logic                                 i_start,
    input  logic                                 i_stop,
    input  logic [NCH-1:0]                       i_chmsk,
    input  logic                                 i_comp,
    output logic                                 o_dac_en,
    output logic [DACW-1:0]                      o_dac_v,
    output logic [NCH-1:0]                       o_sampl_sel,
    output logic                                 o_sh_rst,
    output logic                                 o_sh_hold,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_ch,
    output logic [DACW-1:0]                      o_result,
    output logic                                 o_scan_done
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = (DACW > 1) ? $clog2(DACW) : 1;
    localparam int CW  = $clog2(TSAMP + TSETL + 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_RST    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_CONV   = 3'd5;
    localparam logic [2:0] ST_STORE  = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DACW-1:0] code_q, code_d;

    logic            dac_en_d;
    logic [DACW-1:0] dac_v_d;
    logic [NCH-1:0]  sel_d;
    logic            sh_rst_d;
    logic            sh_hold_d;
    logic            busy_d;
    logic            done_d;
    logic [CHW-1:0]  ch_out_d;
    logic [DACW-1:0] result_d;
    logic            scan_done_d;

    logic [CHW-1:0]  low_idx;
    logic [DACW-1:0] sar_v;

    // Downward scan so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = CHW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        dac_en_d    = o_dac_en;
        dac_v_d     = o_dac_v;
        sel_d       = o_sampl_sel;
        sh_rst_d    = o_sh_rst;
        sh_hold_d   = o_sh_hold;
        done_d      = 1'b0;
        scan_done_d = 1'b0;
        ch_out_d    = o_ch;
        result_d    = o_result;
        sar_v       = o_dac_v;

        if (i_stop && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            mask_d    = '0;
            bit_d     = '0;
            cnt_d     = '0;
            dac_en_d  = 1'b0;
            dac_v_d   = '0;
            sel_d     = '0;
            sh_rst_d  = 1'b0;
            sh_hold_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        if (i_chmsk != '0) begin
                            mask_d  = i_chmsk;
                            state_d = ST_SCAN;
                        end else begin
                            scan_done_d = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (mask_q == '0) begin
                        scan_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        ch_d     = low_idx;
                        sel_d    = {{(NCH-1){1'b0}}, 1'b1} << low_idx;
                        sh_rst_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_RST;
                    end
                end
                ST_RST: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d    = '0;
                        sh_rst_d = 1'b0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_q == CW'(TSAMP - 1)) begin
                        cnt_d     = '0;
                        sel_d     = '0;
                        sh_hold_d = 1'b1;
                        dac_en_d  = 1'b1;
                        dac_v_d   = {1'b1, {(DACW-1){1'b0}}};
                        bit_d     = BW'(DACW - 1);
                        state_d   = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
                ST_CONV: begin
                    if (cnt_q == CW'(TSETL - 1)) begin
                        cnt_d = '0;
                        if (!i_comp) sar_v[bit_q] = 1'b0;
                        if (bit_q != '0) begin
                            sar_v[bit_q - 1'b1] = 1'b1;
                            bit_d   = bit_q - 1'b1;
                            dac_v_d = sar_v;
                        end else begin
                            // Park the finished code; DAC and hold drop in STORE.
                            code_d    = sar_v;
                            dac_v_d   = '0;
                            dac_en_d  = 1'b0;
                            sh_hold_d = 1'b0;
                            state_d   = ST_STORE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STORE: begin
                    result_d     = code_q;
                    ch_out_d     = ch_q;
                    done_d       = 1'b1;
                    mask_d[ch_q] = 1'b0;
                    state_d      = ST_SCAN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            o_dac_en    <= 1'b0;
            o_dac_v     <= '0;
            o_sampl_sel <= '0;
            o_sh_rst    <= 1'b0;
            o_sh_hold   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_ch        <= '0;
            o_result    <= '0;
            o_scan_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            o_dac_en    <= dac_en_d;
            o_dac_v     <= dac_v_d;
            o_sampl_sel <= sel_d;
            o_sh_rst    <= sh_rst_d;
            o_sh_hold   <= sh_hold_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_ch        <= ch_out_d;
            o_result    <= result_d;
            o_scan_done <= scan_done_d;
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Self-checking bench for sar_adc_seq with an ideal comparator model.
// Expected codes equal the channel level; latencies come from phase lengths.
module tb_sar_adc_seq;

    localparam int NCH   = 16;
    localparam int DACW  = 10;
    localparam int TSAMP = 4;
    localparam int TSETL = 3;
    localparam int LAT_CH    = 1 + 2 + TSAMP + 1 + DACW * TSETL + 1;
    localparam int LAT_START = LAT_CH + 1;

    logic        clk = 1'b0;
    logic        rstz = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] chmsk = '0;
    logic        comp;

    logic        o_dac_en;
    logic [9:0]  o_dac_v;
    logic [15:0] o_sampl_sel;
    logic        o_sh_rst;
    logic        o_sh_hold;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_ch;
    logic [9:0]  o_result;
    logic        o_scan_done;

    int ncmp = 0;
    int nfail = 0;
    int cyc_now = 0;
    int cur_ch = 0;
    int n_done = 0;
    int n_sd = 0;
    logic [9:0] lvl [16];
    logic [9:0] exp_res = '0;
    logic [3:0] exp_ch = '0;

    sar_adc_seq #(.NCH(NCH), .DACW(DACW), .TSAMP(TSAMP), .TSETL(TSETL)) dut (
        .i_clk(clk), .i_rstz(rstz), .i_start(start), .i_stop(stop),
        .i_chmsk(chmsk), .i_comp(comp),
        .o_dac_en(o_dac_en), .o_dac_v(o_dac_v), .o_sampl_sel(o_sampl_sel),
        .o_sh_rst(o_sh_rst), .o_sh_hold(o_sh_hold), .o_busy(o_busy),
        .o_done(o_done), .o_ch(o_ch), .o_result(o_result),
        .o_scan_done(o_scan_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    // Remember which channel the sample/hold last connected to.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (o_sampl_sel[i]) cur_ch <= i;
        end
    end

    // Analog input sits half an LSB above its level.
    assign comp = (o_dac_v <= lvl[cur_ch]);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n_done += int'(o_done);
        n_sd   += int'(o_scan_done);
        if (rstz) begin
            check("sel_with_hold", 32'((|o_sampl_sel) & o_sh_hold), 0);
            check("rst_with_hold", 32'(o_sh_rst & o_sh_hold), 0);
            check("sel_onehot0", 32'($onehot0(o_sampl_sel)), 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_dac_en"}, 32'(o_dac_en), 0);
        check({tag, "_dac_v"}, 32'(o_dac_v), 0);
        check({tag, "_sel"}, 32'(o_sampl_sel), 0);
        check({tag, "_sh_rst"}, 32'(o_sh_rst), 0);
        check({tag, "_sh_hold"}, 32'(o_sh_hold), 0);
    endtask

    task automatic start_scan(input logic [15:0] mask, output int t);
        chmsk = mask;
        start = 1'b1;
        t = cyc_now;
        tick();
        start = 1'b0;
        chmsk = 16'($urandom);
    endtask

    task automatic wait_done(input int t_ref, input int lat, input string tag);
        int lim = t_ref + lat + 20;
        while (!o_done && cyc_now < lim) tick();
        check({tag, "_latency"}, 32'(cyc_now - t_ref), 32'(lat));
    endtask

    task automatic run_scan(input logic [15:0] mask, input int t_ref);
        int t = t_ref;
        int lat = LAT_START;
        int sd0 = n_sd;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
                wait_done(t, lat, "done");
                check("ch", 32'(o_ch), 32'(i));
                check("result", 32'(o_result), 32'(lvl[i]));
                check("busy_at_done", 32'(o_busy), 1);
                exp_res = lvl[i];
                exp_ch = 4'(i);
                t = cyc_now;
                lat = LAT_CH;
                tick();
            end
        end
        check("scan_done", 32'(o_scan_done), 1);
        check("busy_fall", 32'(o_busy), 0);
        tick();
        check("scan_done_1cyc", 32'(o_scan_done), 0);
        check("scan_done_count", 32'(n_sd - sd0), 1);
    endtask

    task automatic wait_hold(input int t_ref, input string tag);
        while (!o_dac_en && cyc_now < t_ref + 30) tick();
        check({tag, "_hold_reached"}, 32'(o_dac_en), 1);
    endtask

    initial begin
        int t;
        int sd0;
        int nd0;
        logic [15:0] m;

        for (int i = 0; i < NCH; i++) lvl[i] = '0;

        #1 rstz = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset_done", 32'(o_done), 0);
        check("reset_scan_done", 32'(o_scan_done), 0);
        check("reset_ch", 32'(o_ch), 0);
        check("reset_result", 32'(o_result), 0);
        tick();
        tick();
        rstz = 1'b1;
        tick();

        // Single channel
        lvl[2] = 10'h2A5;
        start_scan(16'h0004, t);
        run_scan(16'h0004, t);

        // Multi-channel with rail levels
        lvl[0] = 10'h000;
        lvl[8] = 10'h3FF;
        lvl[15] = 10'h155;
        start_scan(16'h8101, t);
        run_scan(16'h8101, t);

        // Empty mask
        sd0 = n_sd;
        start_scan(16'h0000, t);
        check("empty_scan_done", 32'(o_scan_done), 1);
        check_idle_outputs("empty");
        tick();
        check("empty_scan_done_1cyc", 32'(o_scan_done), 0);
        check_idle_outputs("empty_after");
        for (int k = 0; k < 5; k++) tick();
        check("empty_sd_count", 32'(n_sd - sd0), 1);

        // Abort on the fifth CONV cycle
        lvl[5] = 10'($urandom_range(0, 1023));
        start_scan(16'h0020, t);
        wait_hold(t, "abort");
        for (int k = 0; k < 5; k++) tick();
        nd0 = n_done;
        sd0 = n_sd;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle_outputs("abort");
        check("abort_result", 32'(o_result), 32'(exp_res));
        check("abort_ch", 32'(o_ch), 32'(exp_ch));
        for (int k = 0; k < 60; k++) tick();
        check("abort_no_done", 32'(n_done - nd0), 0);
        check("abort_no_scan_done", 32'(n_sd - sd0), 0);

        // Stop with start in IDLE
        sd0 = n_sd;
        stop = 1'b1;
        start = 1'b1;
        chmsk = 16'hFFFF;
        tick();
        stop = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("stop_start_busy", 32'(o_busy), 0);
        check("stop_start_no_sd", 32'(n_sd - sd0), 0);

        // Start while busy
        lvl[3] = 10'($urandom_range(0, 1023));
        lvl[9] = 10'($urandom_range(0, 1023));
        start_scan(16'h0208, t);
        while (!((|o_sampl_sel) && !o_sh_rst) && cyc_now < t + 20) tick();
        check("sample_reached", 32'((|o_sampl_sel) & ~o_sh_rst), 1);
        chmsk = 16'h00F0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_scan(16'h0208, t);

        // Async reset mid-CONV
        lvl[6] = 10'($urandom_range(0, 1023));
        start_scan(16'h0040, t);
        wait_hold(t, "arst");
        for (int k = 0; k < 3; k++) tick();
        #2 rstz = 1'b0;
        #1;
        check_idle_outputs("arst");
        check("arst_done", 32'(o_done), 0);
        check("arst_result", 32'(o_result), 0);
        check("arst_ch", 32'(o_ch), 0);
        tick();
        tick();
        rstz = 1'b1;
        exp_res = '0;
        exp_ch = '0;
        tick();
        start_scan(16'h0040, t);
        run_scan(16'h0040, t);

        // Randomized scans
        for (int r = 0; r < 4; r++) begin
            m = 16'($urandom_range(1, 16'hFFFF));
            for (int i = 0; i < NCH; i++) lvl[i] = 10'($urandom_range(0, 1023));
            start_scan(m, t);
            run_scan(m, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
